pipelined_adder: RTL and testbench

//   Parametrised multi-stage ripple-carry adder. Successor to the single-bit full adder.

---
 rtl/pipelined_adder_pkg.sv | 17 +
 rtl/pipelined_adder_slice.sv | 20 ++
 rtl/pipelined_adder.sv | 94 +++++++++
 tb/tb_pipelined_adder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: slice sizing, saturation limits and stage control record shared by pipelined_adder
package pipelined_adder_pkg;
  localparam int max_w = 64;
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;
  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction
  function automatic logic [max_w-1:0] sat_max(input int width);
    return (max_w'(1) << (width - 1)) - max_w'(1);
  endfunction
  function automatic logic [max_w-1:0] sat_min(input int width);
    return max_w'(1) << (width - 1);
  endfunction
endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice: combinational SW-bit ripple of full-adder cells exposing carry out and carry into the MSB
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);
  logic [SW:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < SW; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[SW];
  assign c_msb_in = c[SW-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-pipelined WIDTH-bit adder with valid/ready handshake and signed overflow flag; PIPELINED_ADDER_SAT_EN clamps sum on overflow
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int sw = slice_w(WIDTH, STAGES);
  localparam int last = STAGES - 1;
  localparam logic [WIDTH-1:0] lane = ~({WIDTH{1'b1}} << sw);
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end
  stage_ctl_t ctl_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] a_i [STAGES];
  logic [WIDTH-1:0] b_i [STAGES];
  logic [WIDTH-1:0] s_i [STAGES];
  logic [WIDTH-1:0] s_n [STAGES];
  logic [sw-1:0] ss [STAGES];
  logic [STAGES-1:0] c_i, v_i, co, cm;
  logic [WIDTH-1:0] fin;
  logic adv, ov_n;
  assign out_valid = ctl_q[last].valid;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign a_i[k] = a;
      assign b_i[k] = b;
      assign s_i[k] = '0;
      assign c_i[k] = cin;
      assign v_i[k] = in_valid;
    end else begin : g_body
      assign a_i[k] = a_q[k-1];
      assign b_i[k] = b_q[k-1];
      assign s_i[k] = s_q[k-1];
      assign c_i[k] = ctl_q[k-1].carry;
      assign v_i[k] = ctl_q[k-1].valid;
    end
    adder_slice #(.SW(sw)) u_slice (
      .a        (a_i[k][k*sw +: sw]),
      .b        (b_i[k][k*sw +: sw]),
      .ci       (c_i[k]),
      .s        (ss[k]),
      .co       (co[k]),
      .c_msb_in (cm[k])
    );
    assign s_n[k] = (s_i[k] & ~(lane << (k * sw))) | (WIDTH'(ss[k]) << (k * sw));
  end
  assign ov_n = co[last] ^ cm[last];
`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] sat_hi = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] sat_lo = WIDTH'(sat_min(WIDTH));
  assign fin = ov_n ? (a_i[last][WIDTH-1] ? sat_lo : sat_hi) : s_n[last];
`else
  assign fin = s_n[last];
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) ctl_q[k] <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '{valid: v_i[k], carry: co[k]};
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_n[k];
      end
      if (v_i[last]) begin
        sum <= fin;
        cout <= co[last];
        ovf <= ov_n;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed self-checking bench for pipelined_adder at WIDTH=8, STAGES=2
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  int n_cmp = 0;
  int n_err = 0;
  logic [W+1:0] exp_q [$];
  logic [W-1:0] da [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h80, 8'h00};
  logic [W-1:0] db [5] = '{8'h01, 8'h00, 8'h01, 8'h80, 8'h00};
  logic dc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef PIPELINED_ADDER_SAT_EN
  logic [W+1:0] de [5] = '{10'h010, 10'h100, 10'h27F, 10'h380, 10'h000};
`else
  logic [W+1:0] de [5] = '{10'h010, 10'h100, 10'h280, 10'h300, 10'h000};
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] t;
    logic [W-1:0] s;
    logic v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    s = t[W-1:0];
    v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    if (v) s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {v, t[W], s};
  endfunction

  task automatic chk1(input string tag, input logic got, input logic want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, got, want);
    end
  endtask

  task automatic chkr(input string tag, input logic [W+1:0] got, input logic [W+1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed {ovf,cout,sum}=%h expected %h", tag, got, want);
    end
  endtask

  initial begin
    logic [W+1:0] hold;
    logic stall;
    int sent, rcvd;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chkr("rst_result", {ovf, cout, sum}, '0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = da[i];
      b = db[i];
      cin = dc[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk1("lat1_valid", out_valid, 1'b0);
      if (i > 0) chkr("idle_hold", {ovf, cout, sum}, de[i-1]);
      @(posedge clk);
      #1;
      chk1("lat2_valid", out_valid, 1'b1);
      chkr("directed", {ovf, cout, sum}, de[i]);
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 18; c++) begin
      in_valid = c < 16;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      out_ready = 1'b1;
      #1;
      chk1("stream_valid", out_valid, c >= 2);
      if (out_valid && exp_q.size() > 0) chkr("stream_data", {ovf, cout, sum}, exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      @(posedge clk);
      #1;
    end
    chk1("stream_drained", exp_q.size() == 0, 1'b1);
    exp_q.delete();
    sent = 0;
    rcvd = 0;
    stall = 1'b0;
    hold = '0;
    for (int cyc = 0; cyc < 400 && rcvd < 24; cyc++) begin
      in_valid = (sent < 24) && ($urandom_range(0, 3) != 0);
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk1("in_ready_rule", in_ready, ~out_valid | out_ready);
      if (stall) begin
        chk1("stall_valid", out_valid, 1'b1);
        chkr("stall_hold", {ovf, cout, sum}, hold);
      end
      stall = out_valid & ~out_ready;
      hold = {ovf, cout, sum};
      if (out_valid && out_ready) begin
        rcvd++;
        if (exp_q.size() > 0) chkr("toggle_data", {ovf, cout, sum}, exp_q.pop_front());
        else chk1("toggle_extra", out_valid, 1'b0);
      end
      if (in_valid && in_ready) begin
        sent++;
        exp_q.push_back(model(a, b, cin));
      end
      @(posedge clk);
      #1;
    end
    chk1("toggle_all", rcvd == 24 && exp_q.size() == 0, 1'b1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'h11;
    b = 8'h22;
    cin = 1'b0;
    @(posedge clk);
    #1;
    a = 8'h33;
    b = 8'h44;
    @(posedge clk);
    #1;
    chk1("flight_valid", out_valid, 1'b1);
    chkr("flight_data", {ovf, cout, sum}, 10'h033);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk1("flush_valid", out_valid, 1'b0);
    chkr("flush_result", {ovf, cout, sum}, '0);
    for (int c = 0; c < 4; c++) begin
      chk1("no_stale", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    a = 8'h05;
    b = 8'h03;
    cin = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk1("post_lat1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("post_lat2", out_valid, 1'b1);
    chkr("post_data", {ovf, cout, sum}, 10'h009);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
